// File: rtl/ctrl_pipe_chain_pkg.sv
// Shared definitions for the control-signal pipeline: wait-FSM states and
// default control-word bit positions used by the decoder.
package ctrl_pipe_chain_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } pipeState_e;

    localparam int unsigned CTRL_WIDTH_DEF  = 19;
    localparam int unsigned MEMREQ_BIT_DEF  = 14;
    localparam int unsigned REGWRITE_BIT_DEF = 0;

    // Width of the wait counter; at least one bit even for TIMEOUT 0/1.
    function automatic int unsigned waitCntWidth(input int unsigned timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/ctrl_pipe_chain_stage_reg.sv
// One pipeline stage register: enable, clear-to-bubble and synchronous reset.
module ctrl_stage_reg #(
    parameter int unsigned W = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ctrl_pipe_chain.sv
// Parametrised control-word pipeline with a memory-wait handshake at MEM_STAGE,
// access timeout and saturating stall-cycle counter.
module ctrl_pipe_chain
    import ctrl_pipe_chain_pkg::*;
#(
    parameter int unsigned WIDTH      = 19,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned MEM_STAGE  = 1,
    parameter int unsigned MEMREQ_BIT = 14,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       i_ctrl,
    input  logic                   i_valid,
    input  logic                   i_clear,
    input  logic                   i_mem_ready,
    output logic [DEPTH*WIDTH-1:0] o_stage_ctrl,
    output logic [DEPTH-1:0]       o_stage_valid,
    output logic                   o_mem_req,
    output logic                   o_stall_up,
    output logic                   o_mem_timeout,
    output logic [CNT_W-1:0]       o_stall_cnt
);

    localparam int unsigned WAIT_W = waitCntWidth(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    // Each stage holds {valid, word}.
    logic [WIDTH:0] stageQ [DEPTH];

    pipeState_e        state, nextState;
    logic [WAIT_W-1:0] waitCnt;
    logic              pending, hit, hold;

    assign pending = stageQ[MEM_STAGE][WIDTH] & stageQ[MEM_STAGE][MEMREQ_BIT];

    always_comb begin
        hit  = (TIMEOUT != 0) && (state == WAIT) && (waitCnt == WAIT_LAST)
               && !i_mem_ready;
        hold = pending && !i_mem_ready && !hit;
    end

    assign o_mem_req  = pending;
    assign o_stall_up = hold;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH:0] d;
        logic           en;
        logic           clr;

        if (k == 0) begin : g_first
            assign d   = {i_valid, {WIDTH{i_valid}} & i_ctrl};
            assign en  = ~hold;
            // A clear arriving during a hold is dropped; stage 0 must stay frozen.
            assign clr = i_clear & ~hold;
        end else if (k <= MEM_STAGE) begin : g_held
            assign d   = stageQ[k-1];
            assign en  = ~hold;
            assign clr = 1'b0;
        end else if (k == MEM_STAGE + 1) begin : g_bubble
            assign d   = stageQ[k-1];
            assign en  = 1'b1;
            assign clr = hold | hit;
        end else begin : g_tail
            assign d   = stageQ[k-1];
            assign en  = 1'b1;
            assign clr = 1'b0;
        end

        ctrl_stage_reg #(.W(WIDTH + 1)) u_reg (
            .clk   (clk),
            .reset (reset),
            .en    (en),
            .clr   (clr),
            .d     (d),
            .q     (stageQ[k])
        );

        assign o_stage_ctrl[k*WIDTH +: WIDTH] = stageQ[k][WIDTH-1:0];
        assign o_stage_valid[k]               = stageQ[k][WIDTH];
    end

    always_comb begin
        nextState = state;
        case (state)
            RUN:     if (hold) nextState = WAIT;
            WAIT:    if (i_mem_ready || hit) nextState = RUN;
            default: nextState = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RUN;
            waitCnt       <= '0;
            o_mem_timeout <= 1'b0;
            o_stall_cnt   <= '0;
        end else begin
            state         <= nextState;
            // Held at zero in RUN, so it reads zero on the first WAIT cycle.
            waitCnt       <= (state == RUN) ? '0 : waitCnt + 1'b1;
            o_mem_timeout <= hit;
            if (hold && (o_stall_cnt != '1)) begin
                o_stall_cnt <= o_stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Bench for ctrl_pipe_chain: two instances (TIMEOUT 16/CNT_W 16 and TIMEOUT 4/CNT_W 2)
// share directed stimulus and are checked every cycle against a behavioural model.
module tb_ctrl_pipe_chain;

    localparam int W = 19;
    localparam int D = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  iCtrl = '0;
    logic          iValid = 1'b0;
    logic          iClear = 1'b0;
    logic          iReady = 1'b1;

    logic [D*W-1:0] aCtrl, bCtrl;
    logic [D-1:0]   aValid, bValid;
    logic           aReq, bReq, aStall, bStall, aTmo, bTmo;
    logic [15:0]    aCnt;
    logic [1:0]     bCnt;

    int compared = 0;
    int mismatched = 0;
    int bPulses = 0;
    logic checkOn = 1'b0;

    always #5 clk = ~clk;

    ctrl_pipe_chain dutA (
        .clk(clk), .reset(rst), .i_ctrl(iCtrl), .i_valid(iValid),
        .i_clear(iClear), .i_mem_ready(iReady),
        .o_stage_ctrl(aCtrl), .o_stage_valid(aValid), .o_mem_req(aReq),
        .o_stall_up(aStall), .o_mem_timeout(aTmo), .o_stall_cnt(aCnt)
    );

    ctrl_pipe_chain #(.TIMEOUT(4), .CNT_W(2)) dutB (
        .clk(clk), .reset(rst), .i_ctrl(iCtrl), .i_valid(iValid),
        .i_clear(iClear), .i_mem_ready(iReady),
        .o_stage_ctrl(bCtrl), .o_stage_valid(bValid), .o_mem_req(bReq),
        .o_stall_up(bStall), .o_mem_timeout(bTmo), .o_stall_cnt(bCnt)
    );

    // Model state, index 0 = dutA, 1 = dutB. mStalled counts consecutive stalled
    // cycles of the current access.
    logic         mV [2][D];
    logic [W-1:0] mC [2][D];
    int           mStalled [2];
    logic         mTmo [2];
    int           mCnt [2];
    int           mT [2]   = '{16, 4};
    int           mMax [2] = '{65535, 3};

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < D; k++) begin
                mV[d][k] = 1'b0;
                mC[d][k] = '0;
            end
            mStalled[d] = 0;
            mTmo[d] = 1'b0;
            mCnt[d] = 0;
        end
    end

    function automatic logic mPending(input int d);
        return mV[d][1] && mC[d][1][14];
    endfunction

    function automatic logic mHold(input int d);
        return mPending(d) && !iReady && (mT[d] == 0 || mStalled[d] < mT[d]);
    endfunction

    function automatic logic mHit(input int d);
        return mPending(d) && !iReady && mT[d] != 0 && mStalled[d] == mT[d];
    endfunction

    task automatic modelStep(input int d);
        logic hold, hit;
        hold = mHold(d);
        hit  = mHit(d);
        if (rst) begin
            for (int k = 0; k < D; k++) begin
                mV[d][k] = 1'b0;
                mC[d][k] = '0;
            end
            mStalled[d] = 0;
            mTmo[d] = 1'b0;
            mCnt[d] = 0;
        end else begin
            mTmo[d] = hit;
            if (hold && mCnt[d] < mMax[d]) mCnt[d] = mCnt[d] + 1;
            mStalled[d] = hold ? mStalled[d] + 1 : 0;
            if (hold) begin
                mV[d][2] = 1'b0;
                mC[d][2] = '0;
            end else begin
                mV[d][2] = hit ? 1'b0 : mV[d][1];
                mC[d][2] = hit ? '0 : mC[d][1];
                mV[d][1] = mV[d][0];
                mC[d][1] = mC[d][0];
                mV[d][0] = !iClear && iValid;
                mC[d][0] = (!iClear && iValid) ? iCtrl : '0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            modelStep(0);
            modelStep(1);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (bTmo === 1'b1) bPulses++;
            if (checkOn) begin
                chk("A.stage_ctrl", aCtrl, {mC[0][2], mC[0][1], mC[0][0]});
                chk("A.stage_valid", aValid, {mV[0][2], mV[0][1], mV[0][0]});
                chk("A.mem_req", aReq, mPending(0));
                chk("A.stall_up", aStall, mHold(0));
                chk("A.mem_timeout", aTmo, mTmo[0]);
                chk("A.stall_cnt", aCnt, mCnt[0]);
                chk("B.stage_ctrl", bCtrl, {mC[1][2], mC[1][1], mC[1][0]});
                chk("B.stage_valid", bValid, {mV[1][2], mV[1][1], mV[1][0]});
                chk("B.mem_req", bReq, mPending(1));
                chk("B.stall_up", bStall, mHold(1));
                chk("B.mem_timeout", bTmo, mTmo[1]);
                chk("B.stall_cnt", bCnt, mCnt[1]);
            end
        end
    end

    task automatic cyc(input logic v, input logic [W-1:0] c, input logic clr,
                       input logic rdy, input logic r = 1'b0);
        iValid = v;
        iCtrl  = c;
        iClear = clr;
        iReady = rdy;
        rst    = r;
        @(posedge clk);
        #1;
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
        checkOn = 1'b1;
        chk("lit.reset_valid", aValid, 3'b000);
        chk("lit.reset_cnt", aCnt, 16'd0);

        // Plain stream, no memory requests.
        cyc(1'b1, 19'h00011, 1'b0, 1'b1);
        cyc(1'b1, 19'h00022, 1'b0, 1'b1);
        cyc(1'b1, 19'h00033, 1'b0, 1'b1);
        chk("lit.stream_stage2", aCtrl[2*W +: W], 19'h00011);
        chk("lit.stream_stage0", aCtrl[0 +: W], 19'h00033);
        cyc(1'b1, 19'h00044, 1'b0, 1'b1);
        cyc(1'b1, 19'h00055, 1'b0, 1'b1);
        flush(3);
        chk("lit.stream_cnt", aCnt, 16'd0);

        // Request word waits three cycles; a clear during the hold is ignored.
        cyc(1'b1, 19'h04abc, 1'b0, 1'b1);
        cyc(1'b1, 19'h00101, 1'b0, 1'b1);
        chk("lit.req_pending", aReq, 1'b1);
        cyc(1'b1, 19'h00202, 1'b0, 1'b0);
        cyc(1'b1, 19'h00202, 1'b1, 1'b0);
        cyc(1'b1, 19'h00202, 1'b0, 1'b0);
        chk("lit.hold_stage0", aCtrl[0 +: W], 19'h00101);
        chk("lit.hold_stage1", aCtrl[W +: W], 19'h04abc);
        chk("lit.hold_stage2v", aValid[2], 1'b0);
        chk("lit.hold_cnt", aCnt, 16'd3);
        cyc(1'b1, 19'h00202, 1'b0, 1'b1);
        chk("lit.release_stage2", aCtrl[2*W +: W], 19'h04abc);
        chk("lit.release_valid2", aValid[2], 1'b1);

        // Clear without hold bubbles stage 0.
        cyc(1'b1, 19'h00303, 1'b1, 1'b1);
        chk("lit.clear_valid0", aValid[0], 1'b0);
        chk("lit.clear_word0", aCtrl[0 +: W], 19'h0);
        flush(3);

        // Long wait: dutB aborts after 4 stall cycles, dutA keeps waiting.
        cyc(1'b1, 19'h04def, 1'b0, 1'b1);
        cyc(1'b1, 19'h00404, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        flush(3);
        chk("lit.timeout_pulses", bPulses, 1);
        chk("lit.sat_cnt", bCnt, 2'd3);
        chk("lit.long_cnt", aCnt, 16'd9);

        // Reset in the middle of a wait.
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 19'h04777, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("lit.rst_valid", bValid, 3'b000);
        chk("lit.rst_req", bReq, 1'b0);
        chk("lit.rst_cnt", bCnt, 2'd0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("lit.rst_no_pulse", bPulses, 1);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
